// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and constants for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WR, RD, RD_DONE} state_t;
    localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: external req/ack memory bus between the responder and the memory
interface dmem_responder_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    modport master(output bus_req, bus_we, bus_addr, bus_wdata, input bus_ack, bus_rdata);
    modport slave(input bus_req, bus_we, bus_addr, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: single-entry posted write buffer with load-address forwarding compare
module dmem_wbuf
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        st_req,
    input  logic        ld_req,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        drain_ack,
    input  logic        drop,
    output logic        accept,
    output logic        full,
    output logic        hit,
    output logic [31:0] wbuf_addr,
    output logic [31:0] wbuf_data
);
    // the entry frees in the drain-ack cycle, so a waiting store can refill it at the same edge
    assign accept = st_req & (~full | drain_ack);
    assign hit = ld_req & full & (wbuf_addr[31:2] == addr[31:2]);
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 1'b0;
            wbuf_addr <= '0;
            wbuf_data <= '0;
        end else if (accept) begin
            full      <= 1'b1;
            wbuf_addr <= addr & WORD_MASK;
            wbuf_data <= wdata;
        end else if (drain_ack | drop) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage load/store responder with posted write buffer over a req/ack bus
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_dout,
    input  logic             mem_en,
    output logic [31:0]      mem_din,
    output logic             mem_stall,
    output logic             bus_err,
    output logic             wbuf_empty,
    dmem_responder_if.master bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0] rd_data, wbuf_addr, wbuf_data;
    logic ack, tmo, st_req, ld_miss, full, hit, accept;
    assign ack = bus.bus_req & bus.bus_ack;
    assign tmo = (TIMEOUT != 0) && bus.bus_req && !bus.bus_ack && (cnt == CW'(TIMEOUT - 1));
    // a simultaneous load and store is treated as a load
    assign st_req = mem_wen & ~mem_ren;
    assign ld_miss = mem_ren & ~hit;
    dmem_wbuf u_wbuf (
        .clk(clk),
        .rst(rst),
        .st_req(st_req),
        .ld_req(mem_ren),
        .addr(mem_addr),
        .wdata(mem_dout),
        .drain_ack(state == WR && ack),
        .drop(state == WR && tmo),
        .accept(accept),
        .full(full),
        .hit(hit),
        .wbuf_addr(wbuf_addr),
        .wbuf_data(wbuf_data)
    );
    assign mem_din = hit ? wbuf_data : rd_data;
    assign mem_stall = (ld_miss & (state != RD_DONE)) | (st_req & ~accept);
    assign wbuf_empty = ~full;
    // draining the buffer always wins over a new read to keep program order
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = full ? WR : (ld_miss ? RD : IDLE);
            WR:      state_nx = (ack | tmo) ? IDLE : WR;
            RD:      state_nx = (ack | tmo) ? RD_DONE : RD;
            default: state_nx = mem_en ? IDLE : RD_DONE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            rd_data       <= '0;
            bus_err       <= 1'b0;
            cnt           <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE) begin
                bus.bus_req  <= 1'b1;
                bus.bus_we   <= full;
                bus.bus_addr <= full ? wbuf_addr : (mem_addr & WORD_MASK);
                if (full) bus.bus_wdata <= wbuf_data;
            end else if (ack | tmo) begin
                bus.bus_req <= 1'b0;
            end
            if (state == RD && (ack | tmo)) rd_data <= ack ? bus.bus_rdata : ERR_DATA;
            if (tmo) bus_err <= 1'b1;
            if (state == IDLE || ack) cnt <= '0;
            else if (bus.bus_req && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed load/store traffic checked against a program-order memory model
module tb_dmem_responder;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;
    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
    logic clk = 1'b0, rst = 1'b1;
    logic mem_ren = 1'b0, mem_wen = 1'b0, hold_en = 1'b0;
    logic [31:0] mem_addr = '0, mem_dout = '0;
    logic mem_en, mem_stall, bus_err, wbuf_empty;
    logic [31:0] mem_din;
    logic [31:0] ref_mem [64];
    logic [31:0] bus_mem [64];
    txn_t txq[$];
    int lat_fixed = -1;
    bit tmo_exp = 1'b0;
    int n_tests = 0, n_fail = 0;
    int st, rq;
    dmem_responder_if bus();
    dmem_responder #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_en(mem_en), .mem_din(mem_din), .mem_stall(mem_stall),
        .bus_err(bus_err), .wbuf_empty(wbuf_empty), .bus(bus)
    );
    always #5 clk = ~clk;
    assign mem_en = ~mem_stall & ~hold_en;
    always @(posedge clk) assert (!(mem_ren && mem_wen)) else $error("bench drove load and store together");
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // memory side: ack after a per-request latency, random ack noise while idle
    initial begin
        bit prev = 1'b0;
        int wcnt = 0, lat = 0;
        logic sv_we = 1'b0;
        logic [31:0] sv_addr = '0, sv_wdata = '0;
        bus.bus_ack = 1'b0;
        bus.bus_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.bus_req) begin
                if (!prev) begin
                    wcnt = 0;
                    lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
                    chk("bus_align", 32'(bus.bus_addr[1:0]), 32'd0);
                end else begin
                    chk("hold_addr", bus.bus_addr, sv_addr);
                    chk("hold_we", 32'(bus.bus_we), 32'(sv_we));
                    if (sv_we) chk("hold_wdata", bus.bus_wdata, sv_wdata);
                end
                sv_we = bus.bus_we;
                sv_addr = bus.bus_addr;
                sv_wdata = bus.bus_wdata;
                bus.bus_ack = (wcnt == lat);
                bus.bus_rdata = $urandom;
                if (bus.bus_ack) begin
                    if (bus.bus_we) bus_mem[bus.bus_addr[7:2]] = bus.bus_wdata;
                    else bus.bus_rdata = bus_mem[bus.bus_addr[7:2]];
                    txq.push_back('{bus.bus_we, bus.bus_addr, bus.bus_we ? bus.bus_wdata : bus.bus_rdata});
                end
                wcnt++;
            end else begin
                bus.bus_ack = 1'($urandom_range(0, 1));
                bus.bus_rdata = $urandom;
            end
            prev = bus.bus_req;
        end
    end
    // one pipeline access; called and returning just after a rising edge
    task automatic do_op(input bit ld, input logic [31:0] a, input logic [31:0] d, output int stalls, output int reqs);
        bit done = 1'b0;
        mem_ren = ld;
        mem_wen = !ld;
        mem_addr = a;
        mem_dout = d;
        stalls = 0;
        reqs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.bus_req) reqs++;
            if (!mem_stall && mem_en) begin
                if (ld) chk("load_data", mem_din, tmo_exp ? ERR : ref_mem[a[7:2]]);
                else ref_mem[a[7:2]] = d;
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        chk("op_done", 32'(done), 32'd1);
        mem_ren = 1'b0;
        mem_wen = 1'b0;
    endtask
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wbuf_empty && !bus.bus_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask
    initial begin
        bit ok;
        for (int i = 0; i < 64; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[16] = 32'h1234_5678;
        ref_mem[16] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_din", mem_din, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req", 32'(bus.bus_req), 32'd0);
        chk("rst_we", 32'(bus.bus_we), 32'd0);
        chk("rst_addr", bus.bus_addr, 32'd0);
        chk("rst_wdata", bus.bus_wdata, 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_empty", 32'(wbuf_empty), 32'd1);
        @(posedge clk);
        #1;
        // zero-wait load
        lat_fixed = 0;
        txq.delete();
        do_op(1'b1, 32'h40, 32'd0, st, rq);
        chk("t1_stall", st, 2);
        wait_idle();
        chk("t1_ntx", txq.size(), 1);
        chk("t1_we", 32'(txq[0].we), 32'd0);
        chk("t1_addr", txq[0].addr, 32'h40);
        // posted store then non-matching load
        lat_fixed = 3;
        txq.delete();
        do_op(1'b0, 32'h10, 32'hAAAA_0001, st, rq);
        chk("t2_st_stall", st, 0);
        do_op(1'b1, 32'h20, 32'd0, st, rq);
        chk("t2_ld_stall", st, 10);
        wait_idle();
        chk("t2_ntx", txq.size(), 2);
        chk("t2_w_we", 32'(txq[0].we), 32'd1);
        chk("t2_w_addr", txq[0].addr, 32'h10);
        chk("t2_w_data", txq[0].data, 32'hAAAA_0001);
        chk("t2_r_we", 32'(txq[1].we), 32'd0);
        chk("t2_r_addr", txq[1].addr, 32'h20);
        // store-to-load forward
        lat_fixed = 6;
        txq.delete();
        do_op(1'b0, 32'h80, 32'hCAFE_F00D, st, rq);
        do_op(1'b1, 32'h83, 32'd0, st, rq);
        chk("t3_ld_stall", st, 0);
        wait_idle();
        chk("t3_ntx", txq.size(), 1);
        chk("t3_we", 32'(txq[0].we), 32'd1);
        chk("t3_addr", txq[0].addr, 32'h80);
        // back-to-back stores
        lat_fixed = 4;
        txq.delete();
        do_op(1'b0, 32'h30, 32'h0BAD_0030, st, rq);
        chk("t4_st1_stall", st, 0);
        do_op(1'b0, 32'h34, 32'h0BAD_0034, st, rq);
        chk("t4_st2_stall", st, 5);
        wait_idle();
        chk("t4_ntx", txq.size(), 2);
        chk("t4_addr0", txq[0].addr, 32'h30);
        chk("t4_data0", txq[0].data, 32'h0BAD_0030);
        chk("t4_addr1", txq[1].addr, 32'h34);
        chk("t4_data1", txq[1].data, 32'h0BAD_0034);
        // random traffic over a small address window to provoke forwarding hits
        lat_fixed = -1;
        repeat (150) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            do_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)), $urandom, st, rq);
        end
        wait_idle();
        chk("rand_err", 32'(bus_err), 32'd0);
        for (int i = 0; i < 64; i++) chk("mem_image", bus_mem[i], ref_mem[i]);
        // read data held in RD_DONE while the pipeline does not advance
        lat_fixed = 0;
        txq.delete();
        hold_en = 1'b1;
        mem_ren = 1'b1;
        mem_addr = 32'h44;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mem_stall) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("hold_reach", 32'(ok), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("hold_din", mem_din, ref_mem[17]);
            chk("hold_req", 32'(bus.bus_req), 32'd0);
            chk("hold_ntx", txq.size(), 1);
            @(negedge clk);
        end
        #6 hold_en = 1'b0;
        @(negedge clk);
        chk("hold_last", mem_din, ref_mem[17]);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_exit", 32'(mem_stall), 32'd1);
        @(posedge clk);
        #1 mem_ren = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        // read timeout
        lat_fixed = 1000;
        txq.delete();
        tmo_exp = 1'b1;
        do_op(1'b1, 32'h50, 32'd0, st, rq);
        tmo_exp = 1'b0;
        chk("t5_stall", st, 9);
        chk("t5_req_cycles", rq, 8);
        chk("t5_err", 32'(bus_err), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_err_sticky", 32'(bus_err), 32'd1);
        chk("t5_req_low", 32'(bus.bus_req), 32'd0);
        chk("t5_ntx", txq.size(), 0);
        // reset during an outstanding read
        mem_ren = 1'b1;
        mem_addr = 32'h58;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_pre_req", 32'(bus.bus_req), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        mem_ren = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_req", 32'(bus.bus_req), 32'd0);
        chk("t6_empty", 32'(wbuf_empty), 32'd1);
        chk("t6_err", 32'(bus_err), 32'd0);
        chk("t6_din", mem_din, 32'd0);
        chk("t6_stall", 32'(mem_stall), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_idle_req", 32'(bus.bus_req), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
